// File: rtl/i2c_pkg.sv
// Shared I2C line-conditioning definitions: idle level, default filter depths and
// the per-channel pulse-type encoding that drives o_rise/o_fall/o_glitch.
package i2c_pkg;

  localparam logic I2C_IDLE_LVL = 1'b1;
  localparam int   I2C_DEF_SYNC = 2;
  localparam int   I2C_DEF_FILT = 3;

  // One registered code per channel keeps the three pulses mutually exclusive.
  typedef enum logic [1:0] {
    PULSE_NONE   = 2'd0,
    PULSE_RISE   = 2'd1,
    PULSE_FALL   = 2'd2,
    PULSE_GLITCH = 2'd3
  } pulse_e;

  function automatic pulse_e edge_kind(input logic new_lvl);
    return new_lvl ? PULSE_RISE : PULSE_FALL;
  endfunction

endpackage

// File: rtl/i2c_filter_ch.sv
// One line of the I2C conditioner: synchroniser chain, stability counter,
// filtered level register and registered rise/fall/glitch pulse code.
module i2c_filter_ch
  import i2c_pkg::*;
#(
  parameter int   SYNC_STAGES = I2C_DEF_SYNC,
  parameter int   FILT_CYCLES = I2C_DEF_FILT,
  parameter logic RESET_VAL   = I2C_IDLE_LVL
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_in,
  input  logic i_bypass,
  output logic o_out,
  output logic o_rise,
  output logic o_fall,
  output logic o_glitch
);

  localparam int              CW       = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   out_reg, out_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  pulse_e                 pulse_reg, pulse_next;
  logic                   s;

  assign s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_reg  <= {SYNC_STAGES{RESET_VAL}};
      out_reg   <= RESET_VAL;
      cnt_reg   <= '0;
      pulse_reg <= PULSE_NONE;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], i_in};
      out_reg   <= out_next;
      cnt_reg   <= cnt_next;
      pulse_reg <= pulse_next;
    end
  end

  // Counter only survives while a level change is pending; every other path clears it.
  always_comb begin
    out_next   = out_reg;
    cnt_next   = '0;
    pulse_next = PULSE_NONE;
    if (i_bypass) begin
      out_next = s;
      if (s != out_reg) pulse_next = edge_kind(s);
    end else if (s == out_reg) begin
      if (cnt_reg != '0) pulse_next = PULSE_GLITCH;
    end else if (cnt_reg == CNT_LAST) begin
      out_next   = s;
      pulse_next = edge_kind(s);
    end else begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  assign o_out    = out_reg;
  assign o_rise   = (pulse_reg == PULSE_RISE);
  assign o_fall   = (pulse_reg == PULSE_FALL);
  assign o_glitch = (pulse_reg == PULSE_GLITCH);

endmodule

// File: rtl/i2c_multi_filter.sv
// Multi-channel I2C pad conditioner: N_CH independent glitch filters sharing
// one clock, reset and bypass control.
module i2c_multi_filter
  import i2c_pkg::*;
#(
  parameter int   N_CH        = 2,
  parameter int   SYNC_STAGES = I2C_DEF_SYNC,
  parameter int   FILT_CYCLES = I2C_DEF_FILT,
  parameter logic RESET_VAL   = I2C_IDLE_LVL
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_CH-1:0] i_in,
  input  logic            i_bypass,
  output logic [N_CH-1:0] o_out,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_glitch
);

  if (N_CH < 1) begin : g_bad_n_ch
    $error("i2c_multi_filter: N_CH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("i2c_multi_filter: SYNC_STAGES must be >= 2");
  end
  if (FILT_CYCLES < 1) begin : g_bad_filt
    $error("i2c_multi_filter: FILT_CYCLES must be >= 1");
  end

  genvar gi;
  for (gi = 0; gi < N_CH; gi++) begin : g_ch
    i2c_filter_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES),
      .RESET_VAL   (RESET_VAL)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_in     (i_in[gi]),
      .i_bypass (i_bypass),
      .o_out    (o_out[gi]),
      .o_rise   (o_rise[gi]),
      .o_fall   (o_fall[gi]),
      .o_glitch (o_glitch[gi])
    );
  end

endmodule

// File: tb/tb_i2c_multi_filter.sv
// Bench for i2c_multi_filter: default instance plus a FILT_CYCLES=4 instance,
// table-driven pulse vectors and hand-written reset sequences through a scoreboard.
module tb_i2c_multi_filter;

  typedef struct packed {
    logic [1:0] out;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] glitch;
  } exp_t;

  // Low pulse of 'width' edges on channels in 'mask'; expected event edges are
  // counted from the first posedge that samples the new level (edge 1).
  typedef struct {
    bit         sel;       // 0 = default instance, 1 = FILT_CYCLES=4 instance
    logic [1:0] mask;
    int         width;
    int         byp_lo;    // bypass asserted for edges byp_lo..byp_hi (0 = never)
    int         byp_hi;
    int         fall_e;
    int         rise_e;
    int         glitch_e;
  } vec_t;

  localparam int NVEC = 10;
  localparam int LEN  = 14;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bypass;
  logic [1:0] in_a, in_b;
  logic [1:0] out_a, rise_a, fall_a, glitch_a;
  logic [1:0] out_b, rise_b, fall_b, glitch_b;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  i2c_multi_filter dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_in(in_a), .i_bypass(bypass),
    .o_out(out_a), .o_rise(rise_a), .o_fall(fall_a), .o_glitch(glitch_a)
  );

  i2c_multi_filter #(.FILT_CYCLES(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_in(in_b), .i_bypass(bypass),
    .o_out(out_b), .o_rise(rise_b), .o_fall(fall_b), .o_glitch(glitch_b)
  );

  // Caller drives inputs at the negedge; expectation is pushed, the edge taken,
  // then the DUT output is popped against it 1 time unit later.
  task automatic tick_check(input bit sel, input exp_t want_in, input string tag, input int step);
    exp_t got, want;
    sb_q.push_back(want_in);
    @(posedge clk);
    #1;
    got  = sel ? exp_t'({out_b, rise_b, fall_b, glitch_b})
               : exp_t'({out_a, rise_a, fall_a, glitch_a});
    want = sb_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s edge %0d: got out=%b rise=%b fall=%b glitch=%b, want out=%b rise=%b fall=%b glitch=%b",
               tag, step, got.out, got.rise, got.fall, got.glitch,
               want.out, want.rise, want.fall, want.glitch);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] o, input logic [1:0] r,
                              input logic [1:0] f, input logic [1:0] g);
    exp_t e;
    e.out = o; e.rise = r; e.fall = f; e.glitch = g;
    return e;
  endfunction

  initial begin
    vecs[0] = '{1'b0, 2'b01, 5, 0, 0,  5, 10, 0};  // latency, ch0
    vecs[1] = '{1'b0, 2'b10, 2, 0, 0,  0,  0, 5};  // 2-cycle glitch, ch1
    vecs[2] = '{1'b0, 2'b10, 1, 0, 0,  0,  0, 4};  // 1-cycle glitch, ch1
    vecs[3] = '{1'b0, 2'b11, 3, 0, 0,  5,  8, 0};  // both channels, minimum width
    vecs[4] = '{1'b1, 2'b01, 3, 0, 0,  0,  0, 6};  // FILT=4: 3 cycles rejected
    vecs[5] = '{1'b1, 2'b10, 4, 0, 0,  6, 10, 0};  // FILT=4: 4 cycles accepted
    vecs[6] = '{1'b0, 2'b01, 1, 1, LEN, 3,  4, 0}; // bypass, 1-cycle low
    vecs[7] = '{1'b0, 2'b10, 4, 1, LEN, 3,  7, 0}; // bypass, 4-cycle low
    vecs[8] = '{1'b0, 2'b01, 2, 5, 5,  0,  0, 0};  // bypass pulse mid-count: no glitch
    vecs[9] = '{1'b1, 2'b11, 5, 0, 0,  6, 11, 0};  // FILT=4: both channels

    // Reset held with lines low: idle-high outputs, no pulses.
    rst_n = 1'b0; bypass = 1'b0; in_a = 2'b00; in_b = 2'b11;
    for (int k = 1; k <= 3; k++) tick_check(1'b0, mk(2'b11, 2'b00, 2'b00, 2'b00), "reset_hold", k);

    // Release: low level propagates with normal latency, both falls together.
    @(negedge clk); rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      if (e > 1) @(negedge clk);
      tick_check(1'b0, mk((e >= 5) ? 2'b00 : 2'b11, 2'b00, (e == 5) ? 2'b11 : 2'b00, 2'b00),
                 "reset_release", e);
    end
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk); in_a = 2'b11;
      tick_check(1'b0, mk((e >= 5) ? 2'b11 : 2'b00, (e == 5) ? 2'b11 : 2'b00, 2'b00, 2'b00),
                 "return_high", e);
    end

    // Table-driven pulse vectors.
    for (int v = 0; v < NVEC; v++) begin
      for (int e = 1; e <= LEN; e++) begin
        logic [1:0] drv, o, r, f, g;
        bit         low_win;
        drv     = (e <= vecs[v].width) ? ~vecs[v].mask : 2'b11;
        low_win = (vecs[v].fall_e != 0) && (e >= vecs[v].fall_e) && (e < vecs[v].rise_e);
        o = low_win ? ~vecs[v].mask : 2'b11;
        r = (e == vecs[v].rise_e)   ? vecs[v].mask : 2'b00;
        f = (e == vecs[v].fall_e)   ? vecs[v].mask : 2'b00;
        g = (e == vecs[v].glitch_e) ? vecs[v].mask : 2'b00;
        @(negedge clk);
        bypass = (vecs[v].byp_lo != 0) && (e >= vecs[v].byp_lo) && (e <= vecs[v].byp_hi);
        in_a   = vecs[v].sel ? 2'b11 : drv;
        in_b   = vecs[v].sel ? drv : 2'b11;
        tick_check(vecs[v].sel, mk(o, r, f, g), $sformatf("vec%0d", v), e);
      end
    end

    // Mid-count reset: counter at 2 after edge 4, reset at edge 5 suppresses the fall.
    @(negedge clk); bypass = 1'b0; in_a = 2'b11; in_b = 2'b11;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      in_a  = 2'b10;
      rst_n = (e < 5);
      tick_check(1'b0, mk(2'b11, 2'b00, 2'b00, 2'b00), "midop_reset", e);
    end
    for (int e = 8; e <= 15; e++) begin
      @(negedge clk); in_a = 2'b11; rst_n = 1'b1;
      tick_check(1'b0, mk(2'b11, 2'b00, 2'b00, 2'b00), "after_midop", e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
